// File: rtl/mp3_sync_pkg.sv
// Shared definitions for the MP3 frame-sync front end: state encoding, frame-length
// table, side-info sizes and the CRC-16 constants/update used when CRC_CHECK_EN is defined.
package mp3_sync_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_HUNT = 3'd0;
    localparam state_t ST_HDR2 = 3'd1;
    localparam state_t ST_HDR3 = 3'd2;
    localparam state_t ST_HDR4 = 3'd3;
    localparam state_t ST_CRC1 = 3'd4;
    localparam state_t ST_CRC2 = 3'd5;
    localparam state_t ST_BODY = 3'd6;

    localparam logic [5:0] SIDE_INFO_MONO   = 6'd17;
    localparam logic [5:0] SIDE_INFO_STEREO = 6'd32;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // floor(144 * bitrate / fs) without padding; rows are bitrate_idx 1..14,
    // columns fs_idx 0..2 (44.1k, 48k, 32k).
    localparam logic [10:0] FRAME_LEN [1:14][0:2] = '{
        '{11'd104,  11'd96,  11'd144},
        '{11'd130,  11'd120, 11'd180},
        '{11'd156,  11'd144, 11'd216},
        '{11'd182,  11'd168, 11'd252},
        '{11'd208,  11'd192, 11'd288},
        '{11'd261,  11'd240, 11'd360},
        '{11'd313,  11'd288, 11'd432},
        '{11'd365,  11'd336, 11'd504},
        '{11'd417,  11'd384, 11'd576},
        '{11'd522,  11'd480, 11'd720},
        '{11'd626,  11'd576, 11'd864},
        '{11'd731,  11'd672, 11'd1008},
        '{11'd835,  11'd768, 11'd1152},
        '{11'd1044, 11'd960, 11'd1440}
    };

    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/mp3_crc16_byte.sv
// Byte-wise CRC-16 accumulator (MSB-first). Only built when CRC_CHECK_EN is defined;
// crc_next is the value the register takes if the current byte is absorbed.
`ifdef CRC_CHECK_EN
module mp3_crc16_byte
    import mp3_sync_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    logic [15:0] crc;

    always_comb crc_next = crc16_update(crc, data);

    always_ff @(posedge clock) begin
        if (reset || init) crc <= CRC_INIT;
        else if (en)       crc <= crc_next;
    end

endmodule
`endif

// File: rtl/mp3_frame_sync.sv
// MPEG-1 Layer III frame sync, header parse and body forwarding with lock tracking.
// Define CRC_CHECK_EN to add header/side-info CRC checking and the crc_err output.
module mp3_frame_sync
    import mp3_sync_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   hdr_valid,
    output logic [3:0]             hdr_bitrate_idx,
    output logic [1:0]             hdr_fs_idx,
    output logic [1:0]             hdr_mode,
    output logic [1:0]             hdr_mode_ext,
    output logic                   hdr_padding,
    output logic                   hdr_crc_present,
    output logic                   locked,
    output logic                   sync_lost,
`ifdef CRC_CHECK_EN
    output logic                   crc_err,
`endif
    output logic [FRAME_CNT_W-1:0] frame_count
);

    state_t      state;
    logic        prot;
    logic [3:0]  br;
    logic [1:0]  fs;
    logic        pad;
    logic        lock_flag;
    logic        first_pend;
    logic [10:0] body_left;
    logic [10:0] body_len;
    logic        accept;
    logic        hdr2_ok;
    logic        hdr3_ok;
    logic        hdr_fail;

    always_comb begin
        in_ready = (state != ST_BODY) || !out_valid || out_ready;
        accept   = in_valid && in_ready;
        hdr2_ok  = (in_data & 8'hFE) == 8'hFA;
        hdr3_ok  = (in_data[7:4] != 4'h0) && (in_data[7:4] != 4'hF) && (in_data[3:2] != 2'b11);
        hdr_fail = accept && (((state == ST_HUNT) && (in_data != 8'hFF)) ||
                              ((state == ST_HDR2) && !hdr2_ok) ||
                              ((state == ST_HDR3) && !hdr3_ok));
        // Body excludes the 4 header bytes and, when present, the 2 CRC bytes.
        body_len = FRAME_LEN[br][fs] + {10'd0, pad} - (prot ? 11'd4 : 11'd6);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_HUNT;
            prot            <= 1'b0;
            br              <= 4'd0;
            fs              <= 2'd0;
            pad             <= 1'b0;
            lock_flag       <= 1'b0;
            first_pend      <= 1'b0;
            body_left       <= 11'd0;
            out_data        <= 8'd0;
            out_valid       <= 1'b0;
            out_first       <= 1'b0;
            out_last        <= 1'b0;
            hdr_valid       <= 1'b0;
            hdr_bitrate_idx <= 4'd0;
            hdr_fs_idx      <= 2'd0;
            hdr_mode        <= 2'd0;
            hdr_mode_ext    <= 2'd0;
            hdr_padding     <= 1'b0;
            hdr_crc_present <= 1'b0;
            locked          <= 1'b0;
            sync_lost       <= 1'b0;
            frame_count     <= '0;
        end else begin
            hdr_valid <= 1'b0;
            sync_lost <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end
            // A broken header right after a complete frame means lock is gone.
            if (hdr_fail && lock_flag) begin
                sync_lost <= 1'b1;
                locked    <= 1'b0;
                lock_flag <= 1'b0;
            end
            if (accept) begin
                case (state)
                    ST_HUNT: if (in_data == 8'hFF) state <= ST_HDR2;
                    ST_HDR2: begin
                        if (hdr2_ok) begin
                            prot  <= in_data[0];
                            state <= ST_HDR3;
                        end else if (in_data != 8'hFF) begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_HDR3: begin
                        if (hdr3_ok) begin
                            br    <= in_data[7:4];
                            fs    <= in_data[3:2];
                            pad   <= in_data[1];
                            state <= ST_HDR4;
                        end else begin
                            state <= ST_HUNT;
                        end
                    end
                    ST_HDR4: begin
                        hdr_bitrate_idx <= br;
                        hdr_fs_idx      <= fs;
                        hdr_padding     <= pad;
                        hdr_crc_present <= ~prot;
                        hdr_mode        <= in_data[7:6];
                        hdr_mode_ext    <= in_data[5:4];
                        hdr_valid       <= 1'b1;
                        frame_count     <= frame_count + 1'b1;
                        body_left       <= body_len;
                        first_pend      <= 1'b1;
                        if (lock_flag) begin
                            locked    <= 1'b1;
                            lock_flag <= 1'b0;
                        end
                        state <= prot ? ST_BODY : ST_CRC1;
                    end
                    ST_CRC1: state <= ST_CRC2;
                    ST_CRC2: state <= ST_BODY;
                    ST_BODY: begin
                        out_data   <= in_data;
                        out_valid  <= 1'b1;
                        out_first  <= first_pend;
                        out_last   <= (body_left == 11'd1);
                        first_pend <= 1'b0;
                        body_left  <= body_left - 11'd1;
                        if (body_left == 11'd1) begin
                            lock_flag <= 1'b1;
                            state     <= ST_HUNT;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

`ifdef CRC_CHECK_EN
    logic [15:0] crc_next;
    logic [15:0] rx_crc;
    logic [5:0]  si_left;
    logic        crc_init;
    logic        crc_en;

    // CRC covers header bytes 3-4 and the side info at the start of the body.
    always_comb begin
        crc_init = accept && (state == ST_HDR2);
        crc_en   = accept && ((state == ST_HDR3) || (state == ST_HDR4) ||
                              ((state == ST_BODY) && (si_left != 6'd0)));
    end

    mp3_crc16_byte u_crc (
        .clock    (clock),
        .reset    (reset),
        .init     (crc_init),
        .en       (crc_en),
        .data     (in_data),
        .crc_next (crc_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_err <= 1'b0;
            rx_crc  <= 16'd0;
            si_left <= 6'd0;
        end else begin
            crc_err <= 1'b0;
            if (accept) begin
                case (state)
                    ST_HDR4: si_left <= (in_data[7:6] == 2'b11) ? SIDE_INFO_MONO : SIDE_INFO_STEREO;
                    ST_CRC1, ST_CRC2: rx_crc <= {rx_crc[7:0], in_data};
                    ST_BODY: begin
                        if (si_left != 6'd0) begin
                            si_left <= si_left - 6'd1;
                            if ((si_left == 6'd1) && !prot && (crc_next != rx_crc)) crc_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_mp3_frame_sync.sv
// Self-checking bench for mp3_frame_sync: header vector table plus lock, resync and
// mid-frame reset sequences, with a queue scoreboard on the body byte stream.
module tb_mp3_frame_sync;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_first, out_last;
    logic        hdr_valid;
    logic [3:0]  hdr_bitrate_idx;
    logic [1:0]  hdr_fs_idx, hdr_mode, hdr_mode_ext;
    logic        hdr_padding, hdr_crc_present;
    logic        locked, sync_lost;
    logic [15:0] frame_count;
`ifdef CRC_CHECK_EN
    logic        crc_err;
`endif

    always #5 clock = ~clock;

    mp3_frame_sync #(.FRAME_CNT_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_first       (out_first),
        .out_last        (out_last),
        .hdr_valid       (hdr_valid),
        .hdr_bitrate_idx (hdr_bitrate_idx),
        .hdr_fs_idx      (hdr_fs_idx),
        .hdr_mode        (hdr_mode),
        .hdr_mode_ext    (hdr_mode_ext),
        .hdr_padding     (hdr_padding),
        .hdr_crc_present (hdr_crc_present),
        .locked          (locked),
        .sync_lost       (sync_lost),
`ifdef CRC_CHECK_EN
        .crc_err         (crc_err),
`endif
        .frame_count     (frame_count)
    );

    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0]  b2, b3, b4;
        int          nbody;
        int          nhdr;
        logic [11:0] fields;   // {bitrate, fs, mode, mode_ext, padding, crc_present}
    } vec_t;

    beat_t      exp_q[$];
    logic [7:0] in_q[$];
    int checks = 0, passed = 0;
    int hdr_seen = 0, lost_seen = 0, err_seen = 0, out_seen = 0;
    bit rand_rdy = 0, rand_gap = 0;
    vec_t vecs[11];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    // One clock: drive at the falling edge, then observe what the next rising edge will do.
    task automatic cycle();
        beat_t b;
        @(negedge clock);
        out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (in_q.size() > 0 && !reset && !(rand_gap && $urandom_range(0, 3) == 0)) begin
            in_valid = 1'b1;
            in_data  = in_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'h00;
        end
        #1;
        if (!reset) begin
            if (hdr_valid) hdr_seen++;
            if (sync_lost) lost_seen++;
`ifdef CRC_CHECK_EN
            if (crc_err) err_seen++;
`endif
            if (out_valid && out_ready) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected out byte", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("out beat {data,first,last}", {out_data, out_first, out_last},
                          {b.data, b.first, b.last});
                end
            end
            if (in_valid && in_ready) void'(in_q.pop_front());
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || out_valid) && n < budget) begin
            cycle();
            n++;
        end
        check("stream drained within budget", (in_q.size() == 0 && exp_q.size() == 0) ? 1 : 0, 1);
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        in_q.delete();
        exp_q.delete();
        hdr_seen = 0; lost_seen = 0; err_seen = 0; out_seen = 0;
    endtask

    task automatic check_reset_state();
        check("reset outputs zero",
              {out_valid, out_data, out_first, out_last, hdr_valid, hdr_bitrate_idx, hdr_fs_idx,
               hdr_mode, hdr_mode_ext, hdr_padding, hdr_crc_present, locked, sync_lost}, 0);
        check("reset frame_count", frame_count, 0);
        check("reset in_ready", in_ready, 1);
    endtask

    task automatic push_frame(input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                              input int nbody, input bit flip);
        logic [7:0]  body[$];
        logic [15:0] crc;
        int          si;
        for (int k = 0; k < nbody; k++) body.push_back(8'($urandom_range(0, 255)));
        si  = (b4[7:6] == 2'b11) ? 17 : 32;
        crc = ref_crc(16'hFFFF, b3);
        crc = ref_crc(crc, b4);
        for (int k = 0; k < si && k < nbody; k++) crc = ref_crc(crc, body[k]);
        if (flip && nbody > 5) body[5] = body[5] ^ 8'h10;
        in_q.push_back(8'hFF);
        in_q.push_back(b2);
        in_q.push_back(b3);
        in_q.push_back(b4);
        if (!b2[0]) begin
            in_q.push_back(crc[15:8]);
            in_q.push_back(crc[7:0]);
        end
        for (int k = 0; k < nbody; k++) begin
            beat_t e;
            in_q.push_back(body[k]);
            e.data  = body[k];
            e.first = (k == 0);
            e.last  = (k == nbody - 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'hFB, 8'h90, 8'h64, 413, 1, {4'd9,  2'd0, 2'd1, 2'd2, 1'b0, 1'b0}};
        vecs[1]  = '{8'hFB, 8'h10, 8'hC0, 100, 1, {4'd1,  2'd0, 2'd3, 2'd0, 1'b0, 1'b0}};
        vecs[2]  = '{8'hFB, 8'h52, 8'h00, 205, 1, {4'd5,  2'd0, 2'd0, 2'd0, 1'b1, 1'b0}};
        vecs[3]  = '{8'hFB, 8'hE4, 8'h40, 956, 1, {4'd14, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0}};
        vecs[4]  = '{8'hFB, 8'h18, 8'h30, 140, 1, {4'd1,  2'd2, 2'd0, 2'd3, 1'b0, 1'b0}};
        vecs[5]  = '{8'hFB, 8'hF0, 8'h00, 0,   0, 12'd0};
        vecs[6]  = '{8'hFB, 8'h9C, 8'h00, 0,   0, 12'd0};
        vecs[7]  = '{8'hFB, 8'h00, 8'h00, 0,   0, 12'd0};
        vecs[8]  = '{8'hFA, 8'h90, 8'h64, 411, 1, {4'd9,  2'd0, 2'd1, 2'd2, 1'b0, 1'b1}};
        vecs[9]  = '{8'hF9, 8'h90, 8'h00, 0,   0, 12'd0};
        vecs[10] = '{8'hFA, 8'h10, 8'hC0, 98,  1, {4'd1,  2'd0, 2'd3, 2'd0, 1'b0, 1'b1}};

        do_reset();
        check_reset_state();

        for (int i = 0; i < 11; i++) begin
            do_reset();
            in_q.push_back(8'h00);
            push_frame(vecs[i].b2, vecs[i].b3, vecs[i].b4, vecs[i].nbody, 1'b0);
            drain(5000);
            check("vector hdr_valid pulses", hdr_seen, vecs[i].nhdr);
            check("vector frame_count", frame_count, vecs[i].nhdr);
            check("vector body bytes", out_seen, vecs[i].nbody);
            check("vector header fields",
                  {hdr_bitrate_idx, hdr_fs_idx, hdr_mode, hdr_mode_ext, hdr_padding, hdr_crc_present},
                  vecs[i].fields);
            check("vector sync_lost", lost_seen, 0);
`ifdef CRC_CHECK_EN
            check("vector crc_err on good crc", err_seen, 0);
`endif
        end

        // Back-to-back frames with stalls on both sides: lock on the second header.
        do_reset();
        rand_rdy = 1; rand_gap = 1;
        push_frame(8'hFB, 8'h90, 8'h64, 413, 1'b0);
        drain(5000);
        check("locked after first frame", locked, 0);
        push_frame(8'hFB, 8'h90, 8'h64, 413, 1'b0);
        drain(5000);
        check("locked after second header", locked, 1);
        check("frame_count two frames", frame_count, 2);
        check("body bytes two frames", out_seen, 826);
        rand_rdy = 0; rand_gap = 0;

        // Broken next header, then garbage and resync.
        in_q.push_back(8'hFE);
        drain(100);
        check("sync_lost pulses", lost_seen, 1);
        check("locked after sync loss", locked, 0);
        in_q.push_back(8'h12);
        in_q.push_back(8'h34);
        in_q.push_back(8'hFF);
        push_frame(8'hFB, 8'h90, 8'h64, 413, 1'b0);
        drain(5000);
        check("resync hdr_valid pulses", hdr_seen, 3);
        check("resync frame_count", frame_count, 3);
        check("resync locked stays low", locked, 0);
        check("resync no further sync_lost", lost_seen, 1);

`ifdef CRC_CHECK_EN
        do_reset();
        push_frame(8'hFA, 8'h90, 8'h64, 411, 1'b0);
        drain(5000);
        check("crc_err good crc", err_seen, 0);
        push_frame(8'hFA, 8'h90, 8'h64, 411, 1'b1);
        drain(5000);
        check("crc_err flipped side-info bit", err_seen, 1);
        push_frame(8'hFB, 8'h10, 8'hC0, 100, 1'b1);
        drain(5000);
        check("crc_err absent without crc", err_seen, 1);
`endif

        // Reset in the middle of a frame with random backpressure.
        do_reset();
        rand_rdy = 1; rand_gap = 1;
        push_frame(8'hFB, 8'h90, 8'h64, 413, 1'b0);
        begin
            int n = 0;
            while (out_seen < 200 && n < 5000) begin
                cycle();
                n++;
            end
        end
        check("bytes before mid-frame reset", out_seen, 200);
        do_reset();
        rand_rdy = 0; rand_gap = 0;
        check_reset_state();
        push_frame(8'hFB, 8'h90, 8'h64, 413, 1'b0);
        drain(5000);
        check("post-reset hdr_valid pulses", hdr_seen, 1);
        check("post-reset frame_count", frame_count, 1);
        check("post-reset body bytes", out_seen, 413);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
